pcie_ingress_feeder: RTL and testbench
======================================

Name: pcie_ingress_feeder

Overview:
Upstream source stage for the PCIe interconnect device. It accepts 6-bit words from a host-side valid/ready interface and buffers them in a small local FIFO. Words are pushed into the device's main FIFO (data_in/push_data_in) while MAIN_FIFO_pause is honoured. After reset it also sequences the device's init pulse and keeps per-destination transfer counters for the verification scoreboard.

Parameters:
WORD_SIZE, 6, data word width; bit [4] selects destination (0 = D0, 1 = D1)
BUF_DEPTH, 4, local buffer entries (power of two)
BUF_PTR_L, 2, log2(BUF_DEPTH)
INIT_CYCLES, 2, number of cycles init_out is held high after reset release
CNT_W, 8, width of each transfer counter

Ports:
clk  input  1  single clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
src_valid  input  1  host word valid
src_data  input  WORD_SIZE  host word
src_ready  output  1  feeder can accept a word this cycle
MAIN_FIFO_pause  input  1  device main FIFO almost-full; no push while high
start  input  1  leave IDLE and allow transfers
init_out  output  1  drives device init
push_out  output  1  drives device push_data_in
data_out  output  WORD_SIZE  drives device data_in
state_out  output  2  current FSM state
sent_d0  output  CNT_W  words pushed with bit[4]=0
sent_d1  output  CNT_W  words pushed with bit[4]=1
overflow_err  output  1  sticky: host offered a word while src_ready was low

Behaviour:
- Reset (reset=1 at an edge): state=INIT_S, buffer empty, init_out=0, push_out=0, data_out=0, sent_d0=sent_d1=0, overflow_err=0. Reset has priority over all other events, including mid-transfer. Buffered words are discarded.
- States (encoding in package): INIT_S=0, IDLE=1, ACTIVE=2, PAUSED=3.
- INIT_S: init_out=1 (registered) for exactly INIT_CYCLES cycles after reset release, then 0. Next state is IDLE.
- IDLE: transfers are held. When start=1, next state is ACTIVE.
- ACTIVE: when MAIN_FIFO_pause=1, next state is PAUSED.
- PAUSED: when MAIN_FIFO_pause=0, next state is ACTIVE.
- Transfers always continue until reset; there is no ACTIVE-to-IDLE transition.
- src_ready = (buffer count < BUF_DEPTH) && state != INIT_S. Combinational from registered state only; no input-to-output path.
- Write: src_valid && src_ready at an edge writes src_data into the buffer tail. This is allowed in IDLE and PAUSED, so the buffer fills while output is blocked.
- overflow_err: set when src_valid && !src_ready && state != INIT_S. Cleared only by reset.
- Push: at an edge, if state==ACTIVE && buffer non-empty && MAIN_FIFO_pause==0 (sampled that edge), then:
  - push_out<=1 and data_out<=head word;
  - head is popped;
  - sent_d0 or sent_d1 increments according to head bit[4].
  Otherwise push_out<=0 and data_out holds its last value.
- Latency: a word accepted at edge N appears on data_out with push_out=1 after edge N+1 at the earliest (empty buffer, ACTIVE, no pause). Maximum throughput is 1 word/cycle.
- Pause: the device asserts pause at its almost-full threshold. A pause sampled high at edge N blocks the push at edge N, so no push happens in any cycle where pause was high at the preceding edge.
- Simultaneous write and pop: allowed when not full; count is unchanged and order is preserved (FIFO, no reordering).
- Pointers wrap modulo BUF_DEPTH. Count is BUF_PTR_L+1 bits wide, range 0..BUF_DEPTH.
- Counters wrap modulo 2^CNT_W without flagging.

Decomposition:
- Shared package: state encodings (INIT_S/IDLE/ACTIVE/PAUSED), WORD_SIZE default, DEST_BIT=4 constant.
- One sub-module: feeder_fifo. Synchronous FIFO with push/pop/full/empty/count outputs, parameterised by WORD_SIZE, BUF_DEPTH, BUF_PTR_L.
- FSM, push logic and counters stay in the top.

Test Plan:
1. Reset release with INIT_CYCLES=2 -> init_out=1 for exactly 2 cycles; state_out 0 then 1; src_ready=0 during INIT_S and 1 afterwards.
2. start=1, then words 0x05,0x13,0x2A fed back-to-back, pause=0 -> push_out high 3 consecutive cycles starting one cycle after the first accept; data_out 0x05,0x13,0x2A in order; sent_d0=2, sent_d1=1.
3. Pause mid-stream: raise MAIN_FIFO_pause after the 1st push, hold 5 cycles while feeding 4 more words -> no push while paused; state_out=3; buffer fills to 4; src_ready=0. After release, 4 pushes in order; state_out back to 2.
4. Overflow: buffer full in IDLE, src_valid=1 with 0x3F -> word not stored; overflow_err=1 and stays 1 until reset.
5. Simultaneous write and pop with count=2 in ACTIVE -> count stays 2; output order matches input order across pointer wrap (feed 10 words).
6. Reset asserted mid-transfer with 3 words buffered -> next cycle push_out=0, data_out=0, counters=0, state_out=0. The 3 buffered words are never pushed.

Source files
------------

// File: rtl/pcie_ingress_feeder_pkg.sv
// Shared definitions for the PCIe ingress feeder: FSM states and word layout.
package pcie_ingress_feeder_pkg;

  localparam int WORD_SIZE_DEF = 6;
  // Word bit that selects the destination (0 = D0, 1 = D1)
  localparam int DEST_BIT      = 4;

  typedef enum logic [1:0] {
    INIT_S = 2'd0,
    IDLE   = 2'd1,
    ACTIVE = 2'd2,
    PAUSED = 2'd3
  } state_t;

endpackage

// File: rtl/feeder_fifo.sv
// Small synchronous FIFO buffering host words ahead of the device main FIFO.
// Head word is presented combinationally on o_rdata.
module feeder_fifo #(
  parameter int WORD_SIZE = 6,
  parameter int BUF_DEPTH = 4,
  parameter int BUF_PTR_L = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_push,
  input  logic [WORD_SIZE-1:0] i_wdata,
  input  logic                 i_pop,
  output logic [WORD_SIZE-1:0] o_rdata,
  output logic                 o_full,
  output logic                 o_empty,
  output logic [BUF_PTR_L:0]   o_count
);

  logic [WORD_SIZE-1:0] r_mem [BUF_DEPTH];
  logic [BUF_PTR_L-1:0] r_wr_ptr;
  logic [BUF_PTR_L-1:0] r_rd_ptr;
  logic [BUF_PTR_L:0]   r_count;
  logic                 w_do_push;
  logic                 w_do_pop;

  assign o_full    = (r_count == (BUF_PTR_L+1)'(BUF_DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Storage write at the tail; contents need no reset since count gates reads.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers wrap naturally modulo BUF_DEPTH; count tracks occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/pcie_ingress_feeder.sv
// Upstream feeder: buffers host words, pushes them into the device main FIFO
// honouring its pause, sequences the device init pulse and counts transfers.
module pcie_ingress_feeder
  import pcie_ingress_feeder_pkg::*;
#(
  parameter int WORD_SIZE   = WORD_SIZE_DEF,
  parameter int BUF_DEPTH   = 4,
  parameter int BUF_PTR_L   = 2,
  parameter int INIT_CYCLES = 2,
  parameter int CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 src_valid,
  input  logic [WORD_SIZE-1:0] src_data,
  output logic                 src_ready,
  input  logic                 MAIN_FIFO_pause,
  input  logic                 start,
  output logic                 init_out,
  output logic                 push_out,
  output logic [WORD_SIZE-1:0] data_out,
  output logic [1:0]           state_out,
  output logic [CNT_W-1:0]     sent_d0,
  output logic [CNT_W-1:0]     sent_d1,
  output logic                 overflow_err
);

  localparam int INIT_W = (INIT_CYCLES < 1) ? 1 : $clog2(INIT_CYCLES + 1);

  state_t               r_state;
  state_t               w_next_state;
  logic [INIT_W-1:0]    r_init_cnt;
  logic                 r_init;
  logic                 r_push;
  logic [WORD_SIZE-1:0] r_data;
  logic [CNT_W-1:0]     r_sent_d0;
  logic [CNT_W-1:0]     r_sent_d1;
  logic                 r_overflow;
  logic                 w_init_done;
  logic                 w_wr;
  logic                 w_pop;
  logic [WORD_SIZE-1:0] w_head;
  logic                 w_full;
  logic                 w_empty;
  logic [BUF_PTR_L:0]   w_count;

  assign w_init_done = (r_init_cnt == INIT_W'(INIT_CYCLES));
  assign src_ready   = (w_count < (BUF_PTR_L+1)'(BUF_DEPTH)) && (r_state != INIT_S);
  assign w_wr        = src_valid && src_ready && !w_full;
  assign w_pop       = (r_state == ACTIVE) && !w_empty && !MAIN_FIFO_pause;

  feeder_fifo #(
    .WORD_SIZE (WORD_SIZE),
    .BUF_DEPTH (BUF_DEPTH),
    .BUF_PTR_L (BUF_PTR_L)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_wr),
    .i_wdata (src_data),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= INIT_S;
    else       r_state <= w_next_state;
  end

  // FSM next-state: init -> idle -> active <-> paused; only reset returns to init.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      INIT_S:  if (w_init_done)      w_next_state = IDLE;
      IDLE:    if (start)            w_next_state = ACTIVE;
      ACTIVE:  if (MAIN_FIFO_pause)  w_next_state = PAUSED;
      PAUSED:  if (!MAIN_FIFO_pause) w_next_state = ACTIVE;
      default:                       w_next_state = INIT_S;
    endcase
  end

  // Init pulse: high for INIT_CYCLES cycles after reset release, counted in INIT_S.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_init_cnt <= '0;
      r_init     <= 1'b0;
    end else if ((r_state == INIT_S) && !w_init_done) begin
      r_init_cnt <= r_init_cnt + 1'b1;
      r_init     <= 1'b1;
    end else begin
      r_init     <= 1'b0;
    end
  end

  // Push to device and per-destination counters; data_out holds between pushes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_push    <= 1'b0;
      r_data    <= '0;
      r_sent_d0 <= '0;
      r_sent_d1 <= '0;
    end else begin
      r_push <= w_pop;
      if (w_pop) begin
        r_data <= w_head;
        if (w_head[DEST_BIT]) r_sent_d1 <= r_sent_d1 + CNT_W'(1);
        else                  r_sent_d0 <= r_sent_d0 + CNT_W'(1);
      end
    end
  end

  // Sticky flag for a host word offered while the feeder could not take it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (src_valid && !src_ready && (r_state != INIT_S)) begin
      r_overflow <= 1'b1;
    end
  end

  assign init_out     = r_init;
  assign push_out     = r_push;
  assign data_out     = r_data;
  assign state_out    = r_state;
  assign sent_d0      = r_sent_d0;
  assign sent_d1      = r_sent_d1;
  assign overflow_err = r_overflow;

endmodule

// File: tb/tb_pcie_ingress_feeder.sv
// Self-checking bench for pcie_ingress_feeder: directed scenarios followed by
// random traffic, every cycle compared against a queue-based reference model.
module tb_pcie_ingress_feeder;
  import pcie_ingress_feeder_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       src_valid;
  logic [5:0] src_data;
  logic       src_ready;
  logic       MAIN_FIFO_pause;
  logic       start;
  logic       init_out;
  logic       push_out;
  logic [5:0] data_out;
  logic [1:0] state_out;
  logic [7:0] sent_d0;
  logic [7:0] sent_d1;
  logic       overflow_err;

  int checks = 0;
  int errors = 0;

  // Reference model state
  state_t     m_mode;
  logic [5:0] m_q[$];
  int         m_icnt;
  logic       m_init;
  logic       m_push;
  logic [5:0] m_data;
  logic [7:0] m_s0;
  logic [7:0] m_s1;
  logic       m_ovf;

  logic [5:0] rec[$];
  int         n_init;

  pcie_ingress_feeder #(
    .WORD_SIZE   (6),
    .BUF_DEPTH   (4),
    .BUF_PTR_L   (2),
    .INIT_CYCLES (2),
    .CNT_W       (8)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .src_valid       (src_valid),
    .src_data        (src_data),
    .src_ready       (src_ready),
    .MAIN_FIFO_pause (MAIN_FIFO_pause),
    .start           (start),
    .init_out        (init_out),
    .push_out        (push_out),
    .data_out        (data_out),
    .state_out       (state_out),
    .sent_d0         (sent_d0),
    .sent_d1         (sent_d1),
    .overflow_err    (overflow_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one edge using the inputs currently applied.
  task automatic model_edge();
    logic ready;
    logic [5:0] head;
    if (reset) begin
      m_mode = INIT_S; m_q.delete(); m_icnt = 0; m_init = 0; m_push = 0;
      m_data = '0; m_s0 = '0; m_s1 = '0; m_ovf = 0;
      return;
    end
    ready = (m_q.size() < 4) && (m_mode != INIT_S);
    if (m_mode == ACTIVE && m_q.size() > 0 && !MAIN_FIFO_pause) begin
      head = m_q.pop_front();
      m_push = 1; m_data = head;
      if (head[4]) m_s1 = m_s1 + 8'd1; else m_s0 = m_s0 + 8'd1;
    end else begin
      m_push = 0;
    end
    if (src_valid && ready) m_q.push_back(src_data);
    if (src_valid && !ready && m_mode != INIT_S) m_ovf = 1;
    case (m_mode)
      INIT_S: if (m_icnt < 2) begin m_init = 1; m_icnt++; end
              else begin m_init = 0; m_mode = IDLE; end
      IDLE:   if (start) m_mode = ACTIVE;
      ACTIVE: if (MAIN_FIFO_pause) m_mode = PAUSED;
      PAUSED: if (!MAIN_FIFO_pause) m_mode = ACTIVE;
      default: m_mode = INIT_S;
    endcase
  endtask

  // One clock: model update, then compare every output 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("state", 32'(state_out), 32'(m_mode));
    chk("init", 32'(init_out), 32'(m_init));
    chk("push", 32'(push_out), 32'(m_push));
    chk("data", 32'(data_out), 32'(m_data));
    chk("sent_d0", 32'(sent_d0), 32'(m_s0));
    chk("sent_d1", 32'(sent_d1), 32'(m_s1));
    chk("overflow", 32'(overflow_err), 32'(m_ovf));
    chk("src_ready", 32'(src_ready), 32'((m_q.size() < 4) && (m_mode != INIT_S)));
    if (push_out) rec.push_back(data_out);
    if (init_out) n_init++;
  endtask

  task automatic drive(input logic v, input logic [5:0] d, input logic p, input logic s);
    src_valid = v; src_data = d; MAIN_FIFO_pause = p; start = s;
    step();
  endtask

  initial begin
    reset = 1; src_valid = 0; src_data = '0; MAIN_FIFO_pause = 0; start = 0;
    m_mode = INIT_S; m_icnt = 0; m_init = 0; m_push = 0; m_data = '0;
    m_s0 = '0; m_s1 = '0; m_ovf = 0; n_init = 0;

    // 1: reset, then init pulse of exactly two cycles
    step(); step();
    chk("rst_state", 32'(state_out), 32'd0);
    chk("rst_ready", 32'(src_ready), 32'd0);
    reset = 0;
    n_init = 0;
    for (int i = 0; i < 5; i++) drive(0, '0, 0, 0);
    chk("init_len", 32'(n_init), 32'd2);
    chk("idle_state", 32'(state_out), 32'd1);

    // 2: start, three back-to-back words
    drive(0, '0, 0, 1);
    rec.delete();
    drive(1, 6'h05, 0, 0);
    drive(1, 6'h13, 0, 0);
    drive(1, 6'h2A, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, '0, 0, 0);
    chk("t2_npush", 32'(rec.size()), 32'd3);
    if (rec.size() == 3) begin
      chk("t2_w0", 32'(rec[0]), 32'h05);
      chk("t2_w1", 32'(rec[1]), 32'h13);
      chk("t2_w2", 32'(rec[2]), 32'h2A);
    end
    chk("t2_d0", 32'(sent_d0), 32'd2);
    chk("t2_d1", 32'(sent_d1), 32'd1);

    // 3: pause mid-stream while the buffer fills
    drive(1, 6'h01, 0, 0);
    drive(0, '0, 0, 0);
    drive(1, 6'h11, 1, 0);
    drive(1, 6'h22, 1, 0);
    drive(1, 6'h33, 1, 0);
    drive(1, 6'h0C, 1, 0);
    drive(0, '0, 1, 0);
    chk("t3_state", 32'(state_out), 32'd3);
    chk("t3_ready", 32'(src_ready), 32'd0);
    rec.delete();
    for (int i = 0; i < 6; i++) drive(0, '0, 0, 0);
    chk("t3_npush", 32'(rec.size()), 32'd4);
    chk("t3_state2", 32'(state_out), 32'd2);

    // 4: overflow with full buffer in IDLE
    reset = 1; drive(0, '0, 0, 0); reset = 0;
    for (int i = 0; i < 3; i++) drive(0, '0, 0, 0);
    for (int i = 0; i < 4; i++) drive(1, 6'(i + 8), 0, 0);
    drive(1, 6'h3F, 0, 0);
    chk("t4_ovf", 32'(overflow_err), 32'd1);
    for (int i = 0; i < 3; i++) drive(0, '0, 0, 0);
    drive(0, '0, 0, 1);
    rec.delete();
    for (int i = 0; i < 6; i++) drive(0, '0, 0, 0);
    chk("t4_npush", 32'(rec.size()), 32'd4);
    chk("t4_ovf_sticky", 32'(overflow_err), 32'd1);

    // 5: simultaneous write and pop at count 2 across pointer wrap
    drive(1, 6'h20, 1, 0);
    drive(1, 6'h21, 1, 0);
    drive(0, '0, 0, 0);
    for (int i = 0; i < 10; i++) drive(1, 6'(i * 5 + 1), 0, 0);
    for (int i = 0; i < 4; i++) drive(0, '0, 0, 0);

    // 6: reset mid-transfer with three words buffered
    drive(1, 6'h15, 1, 0);
    drive(1, 6'h16, 1, 0);
    drive(1, 6'h17, 1, 0);
    reset = 1; drive(0, '0, 0, 0); reset = 0;
    chk("t6_push", 32'(push_out), 32'd0);
    chk("t6_data", 32'(data_out), 32'd0);
    chk("t6_cnt", 32'({sent_d1, sent_d0}), 32'd0);
    chk("t6_state", 32'(state_out), 32'd0);
    rec.delete();
    for (int i = 0; i < 3; i++) drive(0, '0, 0, 0);
    drive(0, '0, 0, 1);
    for (int i = 0; i < 5; i++) drive(0, '0, 0, 0);
    chk("t6_npush", 32'(rec.size()), 32'd0);

    // Random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      drive(1'($urandom_range(0, 1)), 6'($urandom), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 7) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
